dot_sprite_drawer: RTL and testbench

//  Consumer of the 8x8 note-dot bitmap ROM: maps each scanned pixel (x,y) from the

---
 rtl/dot_sprite_drawer_if.sv | 45 ++++
 rtl/dot_sprite_drawer.sv | 108 ++++++++++
 tb/tb_dot_sprite_drawer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_sprite_drawer_if.sv
// Bundle between the note-dot drawer and its neighbours: scheduler position offer, video pixel stream, dot ROM, mixer output.
// Latency: none, wires only.
// Backpressure: only the position offer is flow-controlled (pos_valid/pos_ready); the pixel stream and ROM are never stalled.
//
// Signals:
//   pos_valid/pos_ready/pos_x/pos_y/pos_visible : position offer from the note scheduler
//   frame_start                                 : 1-cycle pulse before the first pixel of a frame
//   pix_valid/pix_x/pix_y                       : scanned pixel from the video timing stage
//   rom_addr/rom_data                           : row address to, and row bits from, the 8x8 dot ROM
//   dot_valid/dot_on                            : per-pixel result to the colour mixer
// master = scheduler/video/ROM/mixer side, slave = dot_sprite_drawer.
interface dot_sprite_drawer_if #(
  parameter int DOT_WIDTH  = 8,
  parameter int DOT_HEIGHT = 8,
  parameter int X_WIDTH    = 11,
  parameter int Y_WIDTH    = 10
);
  localparam int RW = $clog2(DOT_HEIGHT);

  logic                 pos_valid;
  logic                 pos_ready;
  logic [X_WIDTH-1:0]   pos_x;
  logic [Y_WIDTH-1:0]   pos_y;
  logic                 pos_visible;
  logic                 frame_start;
  logic                 pix_valid;
  logic [X_WIDTH-1:0]   pix_x;
  logic [Y_WIDTH-1:0]   pix_y;
  logic [RW-1:0]        rom_addr;
  logic [DOT_WIDTH-1:0] rom_data;
  logic                 dot_valid;
  logic                 dot_on;

  modport master (
    output pos_valid, pos_x, pos_y, pos_visible, frame_start,
    output pix_valid, pix_x, pix_y, rom_data,
    input  pos_ready, rom_addr, dot_valid, dot_on
  );

  modport slave (
    input  pos_valid, pos_x, pos_y, pos_visible, frame_start,
    input  pix_valid, pix_x, pix_y, rom_data,
    output pos_ready, rom_addr, dot_valid, dot_on
  );
endinterface

// File: rtl/dot_sprite_drawer.sv
// Maps each scanned pixel onto the active note dot, fetches the dot ROM row and emits a per-pixel dot_on flag.
// Latency: fixed 2 cycles from pix_valid to dot_valid, one pixel per cycle.
// Backpressure: pos_ready drops while a position is pending commit; the pixel path is never stalled.
//
// Ports: clk (rising edge), reset (async, active-high), bus (dot_sprite_drawer_if.slave) carrying the
// position offer, frame_start, pixel stream, ROM address/data and dot_valid/dot_on.
module dot_sprite_drawer #(
  parameter int DOT_WIDTH  = 8,
  parameter int DOT_HEIGHT = 8,
  parameter int X_WIDTH    = 11,
  parameter int Y_WIDTH    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  dot_sprite_drawer_if.slave   bus
);
  localparam int CW = $clog2(DOT_WIDTH);
  localparam int RW = $clog2(DOT_HEIGHT);

  // Double buffer: scheduler writes pending, frame_start moves it to active.
  logic               pend_full;
  logic [X_WIDTH-1:0] pend_x;
  logic [Y_WIDTH-1:0] pend_y;
  logic               pend_vis;
  logic [X_WIDTH-1:0] act_x;
  logic [Y_WIDTH-1:0] act_y;
  logic               act_vis;

  logic accept;
  logic commit;

  assign bus.pos_ready = ~pend_full;
  assign accept        = bus.pos_valid & ~pend_full;
  // accept needs an empty buffer and commit a full one, so they never collide;
  // an offer landing on a frame_start waits for the next frame.
  assign commit        = bus.frame_start & pend_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_full <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      pend_vis  <= 1'b0;
      act_x     <= '0;
      act_y     <= '0;
      act_vis   <= 1'b0;
    end else if (accept) begin
      pend_x    <= bus.pos_x;
      pend_y    <= bus.pos_y;
      pend_vis  <= bus.pos_visible;
      pend_full <= 1'b1;
    end else if (commit) begin
      act_x     <= pend_x;
      act_y     <= pend_y;
      act_vis   <= pend_vis;
      pend_full <= 1'b0;
    end
  end

  // Window bounds carry one extra bit so a dot near the right/bottom edge does not wrap to column/row 0.
  logic [X_WIDTH:0] x_end;
  logic [Y_WIDTH:0] y_end;
  logic             hit;
  logic [CW-1:0]    col_d;
  logic [RW-1:0]    row_d;

  assign x_end = {1'b0, act_x} + (X_WIDTH+1)'(DOT_WIDTH);
  assign y_end = {1'b0, act_y} + (Y_WIDTH+1)'(DOT_HEIGHT);
  assign hit   = act_vis
               & (bus.pix_x >= act_x) & ({1'b0, bus.pix_x} < x_end)
               & (bus.pix_y >= act_y) & ({1'b0, bus.pix_y} < y_end);
  // Only the low bits of the offset are needed inside the window.
  assign col_d = CW'(bus.pix_x) - CW'(act_x);
  assign row_d = RW'(bus.pix_y) - RW'(act_y);

  logic          v1;
  logic          hit1;
  logic [CW-1:0] col1;
  logic [RW-1:0] rom_addr_q;
  logic          dot_valid_q;
  logic          dot_on_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1          <= 1'b0;
      hit1        <= 1'b0;
      col1        <= '0;
      rom_addr_q  <= '0;
      dot_valid_q <= 1'b0;
      dot_on_q    <= 1'b0;
    end else begin
      // Stage 1: address the ROM row; the address holds on misses to avoid needless toggling.
      v1   <= bus.pix_valid;
      hit1 <= hit;
      col1 <= col_d;
      if (bus.pix_valid && hit) begin
        rom_addr_q <= row_d;
      end
      // Stage 2: rom_data now reflects rom_addr_q; MSB is the leftmost column.
      dot_valid_q <= v1;
      dot_on_q    <= v1 & hit1 & bus.rom_data[CW'(DOT_WIDTH-1) - col1];
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.dot_valid = dot_valid_q;
  assign bus.dot_on    = dot_on_q;
endmodule

// File: tb/tb_dot_sprite_drawer.sv
// Bench for dot_sprite_drawer: drives positions and pixel sweeps, queues the expected dot_on per pixel and checks
// each output against it, including the 2-cycle latency.
// Backpressure: the position offer waits on pos_ready with a bounded loop.
module tb_dot_sprite_drawer;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam logic [7:0] ROM_IMG [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dot_sprite_drawer_if #(.DOT_WIDTH(8), .DOT_HEIGHT(8), .X_WIDTH(XW), .Y_WIDTH(YW)) sif ();

  dot_sprite_drawer #(.DOT_WIDTH(8), .DOT_HEIGHT(8), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  // Dot ROM: combinational from rom_addr.
  assign sif.rom_data = ROM_IMG[sif.rom_addr];

  typedef struct {
    logic on;
    int   due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   hits = 0;
  int   m_x = 0;
  int   m_y = 0;
  logic m_vis = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected dot_on for a pixel against the bench's own notion of the active position.
  function automatic logic exp_dot(int px, int py);
    logic [7:0] r;
    if (!m_vis) return 1'b0;
    if (px < m_x || px >= m_x + 8 || py < m_y || py >= m_y + 8) return 1'b0;
    r = ROM_IMG[py - m_y];
    return r[7 - (px - m_x)];
  endfunction

  // Output monitor: pops one expectation per dot_valid and checks value and arrival cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (sif.dot_on && !sif.dot_valid) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL on_without_valid: dot_on=%0b dot_valid=%0b required dot_on=0", sif.dot_on, sif.dot_valid);
      end
      if (sif.dot_valid) begin
        total = total + 1;
        if (sb.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_valid: dot_valid=1 at cycle %0d, required no output", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (sif.dot_on !== e.on || cyc != e.due) begin
            bad = bad + 1;
            $display("FAIL pixel: dot_on=%0b at cycle %0d, required %0b at cycle %0d", sif.dot_on, cyc, e.on, e.due);
          end
          if (sif.dot_on) hits = hits + 1;
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        total = total + 1;
        bad = bad + 1;
        $display("FAIL missing_valid: dot_valid=0 at cycle %0d, required result %0b due cycle %0d", cyc, e.on, e.due);
      end
    end
  end

  task automatic drive_pix(int px, int py, logic vld);
    exp_t e;
    @(negedge clk);
    sif.pix_valid = vld;
    sif.pix_x = XW'(px);
    sif.pix_y = YW'(py);
    if (vld) begin
      e.on = exp_dot(px, py);
      e.due = cyc + 2;
      sb.push_back(e);
    end
  endtask

  // Raster over a window with a periodic bubble that points at a hit pixel but is not valid.
  task automatic sweep(int x0, int y0, int w, int h);
    int k = 0;
    for (int y = y0; y < y0 + h; y++) begin
      for (int x = x0; x < x0 + w; x++) begin
        if (k % 7 == 6) drive_pix(m_x + 2, m_y + 3, 1'b0);
        drive_pix(x, y, 1'b1);
        k++;
      end
    end
    drive_pix(0, 0, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic offer(int x, int y, logic vis);
    int n = 0;
    @(negedge clk);
    sif.pos_valid = 1'b1;
    sif.pos_x = XW'(x);
    sif.pos_y = YW'(y);
    sif.pos_visible = vis;
    while (!sif.pos_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total = total + 1;
    if (n >= 50) begin
      bad = bad + 1;
      $display("FAIL offer_timeout: pos_ready=%0b after %0d cycles, required 1", sif.pos_ready, n);
    end
    @(negedge clk);
    sif.pos_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    sif.frame_start = 1'b1;
    @(negedge clk);
    sif.frame_start = 1'b0;
  endtask

  task automatic check_ready(string name, logic req);
    total = total + 1;
    if (sif.pos_ready !== req) begin
      bad = bad + 1;
      $display("FAIL %s: pos_ready=%0b required %0b", name, sif.pos_ready, req);
    end
  endtask

  task automatic check_hits(string name, int req);
    total = total + 1;
    if (hits != req) begin
      bad = bad + 1;
      $display("FAIL %s: dot_on count=%0d required %0d", name, hits, req);
    end
  endtask

  task automatic test_reset();
    #1;
    total = total + 1;
    if (sif.pos_ready !== 1'b1 || sif.rom_addr !== 3'd0 || sif.dot_valid !== 1'b0 || sif.dot_on !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL reset_state: ready=%0b addr=%0d valid=%0b on=%0b required 1 0 0 0",
               sif.pos_ready, sif.rom_addr, sif.dot_valid, sif.dot_on);
    end
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    sweep(0, 0, 16, 16);
    sweep(624, 464, 16, 16);
    sweep(96, 46, 16, 16);
    check_hits("no_position_hits", 0);
    check_ready("reset_ready", 1'b1);
  endtask

  task automatic test_basic_dot();
    offer(100, 50, 1'b1);
    check_ready("pending_full", 1'b0);
    pulse_frame();
    m_x = 100; m_y = 50; m_vis = 1'b1;
    check_ready("after_commit", 1'b1);
    hits = 0;
    sweep(96, 46, 16, 16);
    check_hits("dot_100_50", 52);
  endtask

  task automatic test_back_to_back();
    offer(500, 300, 1'b1);
    @(negedge clk);
    sif.pos_valid = 1'b1;
    sif.pos_x = XW'(600);
    sif.pos_y = YW'(400);
    sif.pos_visible = 1'b1;
    check_ready("b_held_off", 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_ready("b_still_held", 1'b0);
    end
    sif.frame_start = 1'b1;
    @(negedge clk);
    sif.frame_start = 1'b0;
    m_x = 500; m_y = 300;
    check_ready("ready_after_a_commit", 1'b1);
    @(negedge clk);
    sif.pos_valid = 1'b0;
    check_ready("b_accepted", 1'b0);
    hits = 0;
    sweep(498, 298, 12, 12);
    check_hits("a_drawn", 52);
    hits = 0;
    sweep(598, 398, 12, 12);
    check_hits("b_not_yet", 0);
    pulse_frame();
    m_x = 600; m_y = 400;
    hits = 0;
    sweep(598, 398, 12, 12);
    check_hits("b_drawn", 52);
  endtask

  task automatic test_coincident();
    @(negedge clk);
    sif.frame_start = 1'b1;
    sif.pos_valid = 1'b1;
    sif.pos_x = XW'(200);
    sif.pos_y = YW'(0);
    sif.pos_visible = 1'b1;
    check_ready("coincident_ready", 1'b1);
    @(negedge clk);
    sif.frame_start = 1'b0;
    sif.pos_valid = 1'b0;
    check_ready("coincident_pending", 1'b0);
    hits = 0;
    sweep(598, 398, 12, 12);
    check_hits("old_dot_kept", 52);
    hits = 0;
    sweep(196, 0, 12, 12);
    check_hits("new_dot_waits", 0);
    pulse_frame();
    m_x = 200; m_y = 0;
    hits = 0;
    sweep(196, 0, 12, 12);
    check_hits("new_dot_drawn", 52);
  endtask

  task automatic test_edge();
    offer(2044, 1020, 1'b1);
    pulse_frame();
    m_x = 2044; m_y = 1020;
    hits = 0;
    sweep(2036, 1014, 12, 10);
    check_hits("edge_in_range", 13);
    hits = 0;
    sweep(0, 1016, 6, 8);
    sweep(0, 0, 6, 6);
    sweep(2040, 0, 8, 6);
    check_hits("edge_no_wrap", 0);
  endtask

  task automatic test_reset_mid_frame();
    offer(300, 200, 1'b1);
    pulse_frame();
    m_x = 300; m_y = 200;
    offer(400, 100, 1'b1);
    drive_pix(302, 202, 1'b1);
    drive_pix(303, 203, 1'b1);
    drive_pix(304, 204, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total = total + 1;
    if (sif.dot_valid !== 1'b0 || sif.dot_on !== 1'b0 || sif.rom_addr !== 3'd0 || sif.pos_ready !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL mid_reset: valid=%0b on=%0b addr=%0d ready=%0b required 0 0 0 1",
               sif.dot_valid, sif.dot_on, sif.rom_addr, sif.pos_ready);
    end
    sb.delete();
    sif.pix_valid = 1'b0;
    m_vis = 1'b0; m_x = 0; m_y = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    sweep(296, 196, 12, 12);
    pulse_frame();
    sweep(396, 96, 12, 12);
    check_hits("nothing_after_reset", 0);
    check_ready("pending_discarded", 1'b1);
    offer(400, 100, 1'b1);
    pulse_frame();
    m_x = 400; m_y = 100; m_vis = 1'b1;
    hits = 0;
    sweep(396, 96, 12, 12);
    check_hits("redraw_after_reset", 52);
  endtask

  initial begin
    sif.pos_valid = 1'b0;
    sif.pos_x = '0;
    sif.pos_y = '0;
    sif.pos_visible = 1'b0;
    sif.frame_start = 1'b0;
    sif.pix_valid = 1'b0;
    sif.pix_x = '0;
    sif.pix_y = '0;
    test_reset();
    test_basic_dot();
    test_back_to_back();
    test_coincident();
    test_edge();
    test_reset_mid_frame();
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
